// File: rtl/dac_seq_pkg.sv
// Shared types and constants for the 8-bit DAC sample sequencer.
package dac_seq_pkg;

  localparam int DAC_CODE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/dac_seq_fifo.sv
// Sample FIFO for the DAC sequencer: registered occupancy, show-ahead head entry.
module dac_seq_fifo
  import dac_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = DAC_CODE_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] level,
  output logic                   empty,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          wr_en;
  logic          rd_en;

  assign empty = (level == '0);
  assign full  = (level == FULL_LVL);
  assign rdata = mem[rptr];
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/dac_8bit_sequencer.sv
// Paced 8-bit DAC sample sequencer: FIFO-fed, divider-timed, IDLE/PRIME/RUN FSM.
// Optional ramp generator (ramp_mode input) is built when DAC_SEQ_RAMP_EN is defined.
module dac_8bit_sequencer
  import dac_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DIV_W = 16
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   enable,
  input  logic [DIV_W-1:0]       div,
`ifdef DAC_SEQ_RAMP_EN
  input  logic                   ramp_mode,
`endif
  input  logic [DAC_CODE_W-1:0]  s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [DAC_CODE_W-1:0]  dac_code,
  output logic                   dac_ena,
  output logic                   underflow,
  output logic [$clog2(DEPTH):0] level,
  output state_t                 dbg_state
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] HALF_LVL = LW'(DEPTH / 2);

`ifdef DAC_SEQ_RAMP_EN
  logic ramp_on;
  assign ramp_on = ramp_mode;
`else
  localparam logic ramp_on = 1'b0;
`endif

  state_t                  state_q;
  state_t                  state_d;
  logic [DIV_W-1:0]        cnt_q;
  logic                    tick;
  logic                    push;
  logic                    pop;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic [DAC_CODE_W-1:0]   head;

  assign s_ready   = !fifo_full;
  assign push      = s_valid && s_ready;
  // A tick is only honoured while RUN is being held; the cycle enable drops
  // leaves the FIFO untouched so no sample is consumed on the way out.
  assign tick      = (state_q == RUN) && enable && (cnt_q == div);
  assign pop       = tick && !ramp_on && !fifo_empty;
  assign dbg_state = state_q;

  dac_seq_fifo #(
    .DEPTH (DEPTH),
    .W     (DAC_CODE_W)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (push),
    .wdata (s_data),
    .pop   (pop),
    .rdata (head),
    .level (level),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = PRIME;
      PRIME: begin
        if (!enable)                            state_d = IDLE;
        else if (ramp_on || level >= HALF_LVL)  state_d = RUN;
      end
      RUN:     if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dac_code  <= '0;
      dac_ena   <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state_q   <= state_d;
      dac_ena   <= (state_d == RUN);
      underflow <= tick && !ramp_on && fifo_empty;

      if ((state_d == RUN) && (state_q != RUN)) cnt_q <= '0;
      else if (tick)                            cnt_q <= '0;
      else if (state_q == RUN)                  cnt_q <= cnt_q + 1'b1;

      if (state_d != RUN)        dac_code <= '0;
      else if (pop)              dac_code <= head;
      else if (tick && ramp_on)  dac_code <= dac_code + 1'b1;
    end
  end

endmodule
